// File: rtl/seg7_scan_display_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_display_if
//   Bundles the data-in and display-out signals of the 4-digit 7-segment
//   scanner so the producer side and the display driver share one connection.
//
//   value       16  data to display
//   load         1  capture value this cycle
//   seg          7  segments {g,f,e,d,c,b,a}
//   dp           1  decimal point (always inactive)
//   an           4  digit enables, an[0] = rightmost digit
//   frame_tick   1  one-cycle pulse when the digit index wraps 3->0
//
//   master : the side that supplies value/load and observes the display pins
//   slave  : the display driver itself
// ----------------------------------------------------------------------------
interface seg7_scan_display_if;
  logic [15:0] value;
  logic        load;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  modport master (
    output value, load,
    input  seg, dp, an, frame_tick
  );

  modport slave (
    input  value, load,
    output seg, dp, an, frame_tick
  );
endinterface

// File: rtl/seg7_scan_display.sv
// ----------------------------------------------------------------------------
// seg7_scan_display
//   Shows a 16-bit value in hex on a 4-digit time-multiplexed 7-segment
//   display. A load strobe captures the value into a pending register; the
//   pending value is committed to the displayed register only at a frame
//   boundary, so a frame never mixes digits of two different values. Each
//   digit owns one slot of REFRESH_DIV cycles; the first GUARD cycles of every
//   slot keep all anodes off to avoid ghosting while segments settle.
//   Leading zero digits can be blanked (digit 0 is always shown).
//
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    seg7_scan_display_if.slave : value/load in, seg/dp/an/frame_tick out
//
//   All display outputs are registered and reflect the counter, digit index
//   and displayed value of the previous cycle.
// ----------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int REFRESH_DIV    = 50000,  // cycles per digit slot, >= 4
  parameter int GUARD          = 16,     // anode-off cycles at slot start, < REFRESH_DIV
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEADING  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  seg7_scan_display_if.slave   bus
);

  localparam int CW = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_OFF  = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;

  // Hex digit to segment pattern, active-high form {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      4'hF: s = 7'h71;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Scan and data state
  logic [CW-1:0] cnt;
  logic [1:0]    dig;
  logic [15:0]   disp;
  logic [15:0]   pend;
  logic          pend_valid;

  // Registered outputs
  logic [6:0]    seg_q;
  logic [3:0]    an_q;
  logic          frame_tick_q;

  // Combinational next-output terms
  logic          slot_end;
  logic          tick;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg_hi;
  logic [3:0]    an_hi;

  assign slot_end = (cnt == CW'(REFRESH_DIV - 1));
  assign tick     = slot_end && (dig == 2'd3);
  assign nib      = disp[{dig, 2'b00} +: 4];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    blank = 1'b0;
    if (BLANK_LEADING) begin
      unique case (dig)
        2'd1:    blank = (disp[15:4]  == 12'h000);
        2'd2:    blank = (disp[15:8]  == 8'h00);
        2'd3:    blank = (disp[15:12] == 4'h0);
        default: blank = 1'b0;
      endcase
    end

    seg_hi = blank ? 7'h00 : hex_to_seg(nib);
    an_hi  = 4'b0000;
    // The guard window keeps the digit dark while the segment lines move.
    if ((cnt >= CW'(GUARD)) && !blank)
      an_hi = 4'b0001 << dig;
  end

  // NOTE: state registers use non-blocking assignments so every update sees
  // the pre-edge values of the others (e.g. commit reads the old pend while a
  // simultaneous load overwrites it).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt          <= '0;
      dig          <= 2'd0;
      disp         <= 16'h0000;
      pend         <= 16'h0000;
      pend_valid   <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // Commit at the frame boundary; a load in the same cycle lands in pend
      // and waits for the following frame.
      if (tick && pend_valid)
        disp <= pend;

      if (bus.load) begin
        pend       <= bus.value;
        pend_valid <= 1'b1;
      end else if (tick) begin
        pend_valid <= 1'b0;
      end

      seg_q        <= SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
      an_q         <= SEG_ACTIVE_LOW ? ~an_hi  : an_hi;
      frame_tick_q <= tick;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.dp         = SEG_ACTIVE_LOW;  // decimal point never lit

endmodule
